// File: rtl/baccarat_pkg.sv
// Shared card types, state encoding and point-value helper for the Baccarat display path.
package baccarat_pkg;

   typedef logic [3:0] card_t;

   localparam card_t CARD_EMPTY = 4'd0;
   localparam card_t CARD_KING  = 4'd13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SCORE = 2'd2
   } deal_state_t;

   // Ten and the court cards count zero; an empty slot also counts zero.
   function automatic card_t card_points(card_t c);
      return (c <= 4'd9) ? c : 4'd0;
   endfunction

endpackage

// File: rtl/shoe_counter.sv
// Free-running shoe: cycles card codes 1..CARD_MAX, stepping once every ADV_DIV clocks.
module shoe_counter
   import baccarat_pkg::*;
#(
   parameter int CARD_MAX = 13,
   parameter int ADV_DIV  = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   output logic [3:0] next_card_o
);

   logic [3:0] div_q, div_d;
   card_t      card_q, card_d;

   always_comb begin
      div_d  = div_q + 4'd1;
      card_d = card_q;
      if (div_q >= 4'(ADV_DIV - 1)) begin
         div_d  = 4'd0;
         card_d = (card_q >= card_t'(CARD_MAX)) ? 4'd1 : card_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q  <= 4'd0;
         card_q <= 4'd1;
      end else begin
         div_q  <= div_d;
         card_q <= card_d;
      end
   end

   assign next_card_o = card_q;

endmodule

// File: rtl/hand_dealer.sv
// Deals one Baccarat hand of up to three cards from the shoe and keeps the running score.
// Optional macro HAND_DEALER_NATURAL_EN: flag a natural 8/9 on two cards and freeze the hand.
module hand_dealer
   import baccarat_pkg::*;
#(
   parameter int CARD_MAX = 13,
   parameter int ADV_DIV  = 1
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       deal_req,
   input  logic       clear_hand,
   output logic [3:0] next_card,
   output logic [3:0] card1,
   output logic [3:0] card2,
   output logic [3:0] card3,
   output logic [1:0] ncards,
   output logic [3:0] score,
   output logic       deal_ack,
   output logic       busy,
   output logic       hand_full,
   output logic       natural
);

   deal_state_t state_q;
   card_t       card1_q, card2_q, card3_q;
   card_t       pts_q;
   logic [1:0]  ncards_q;
   logic [3:0]  score_q;
   logic        ack_q;
   logic        nat_q;
   logic        blocked;
   logic [4:0]  sum_w;
   logic [3:0]  score_new;

   shoe_counter #(
      .CARD_MAX(CARD_MAX),
      .ADV_DIV (ADV_DIV)
   ) u_shoe (
      .clk_i      (clock),
      .rst_ni     (resetb),
      .next_card_o(next_card)
   );

   assign sum_w     = {1'b0, score_q} + {1'b0, pts_q};
   assign score_new = (sum_w >= 5'd10) ? 4'(sum_w - 5'd10) : sum_w[3:0];
   assign hand_full = (ncards_q == 2'd3);

`ifdef HAND_DEALER_NATURAL_EN
   assign blocked = hand_full | nat_q;
`else
   assign blocked = hand_full;
`endif

   // Outputs are registered, so each state's visible effect is written on the edge
   // entering it: the card lands as LOAD begins, score and ack as SCORE begins.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q  <= IDLE;
         card1_q  <= CARD_EMPTY;
         card2_q  <= CARD_EMPTY;
         card3_q  <= CARD_EMPTY;
         pts_q    <= 4'd0;
         ncards_q <= 2'd0;
         score_q  <= 4'd0;
         ack_q    <= 1'b0;
         nat_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (clear_hand) begin
            state_q  <= IDLE;
            card1_q  <= CARD_EMPTY;
            card2_q  <= CARD_EMPTY;
            card3_q  <= CARD_EMPTY;
            ncards_q <= 2'd0;
            score_q  <= 4'd0;
            nat_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (deal_req && !blocked) begin
                     case (ncards_q)
                        2'd0:    card1_q <= next_card;
                        2'd1:    card2_q <= next_card;
                        default: card3_q <= next_card;
                     endcase
                     pts_q    <= card_points(next_card);
                     ncards_q <= ncards_q + 2'd1;
                     state_q  <= LOAD;
                  end
               end
               LOAD: begin
                  score_q <= score_new;
                  ack_q   <= 1'b1;
`ifdef HAND_DEALER_NATURAL_EN
                  if (ncards_q == 2'd2 && score_new >= 4'd8)
                     nat_q <= 1'b1;
`endif
                  state_q <= SCORE;
               end
               SCORE:   state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign card1    = card1_q;
   assign card2    = card2_q;
   assign card3    = card3_q;
   assign ncards   = ncards_q;
   assign score    = score_q;
   assign deal_ack = ack_q;
   assign busy     = (state_q != IDLE);
`ifdef HAND_DEALER_NATURAL_EN
   assign natural  = nat_q;
`else
   assign natural  = 1'b0;
`endif

endmodule

// File: tb/tb_hand_dealer.sv
// Self-checking bench for hand_dealer: directed table, hand sequences, random vs. reference model.
module tb_hand_dealer;

`ifdef HAND_DEALER_NATURAL_EN
   localparam bit NAT = 1'b1;
`else
   localparam bit NAT = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       resetb = 1'b0;
   logic       deal_req = 1'b0;
   logic       clear_hand = 1'b0;
   logic [3:0] next_card, card1, card2, card3, score;
   logic [1:0] ncards;
   logic       deal_ack, busy, hand_full, natural;

   int n_chk = 0;
   int n_fail = 0;

   hand_dealer #(.CARD_MAX(13), .ADV_DIV(1)) dut (
      .clock     (clock),
      .resetb    (resetb),
      .deal_req  (deal_req),
      .clear_hand(clear_hand),
      .next_card (next_card),
      .card1     (card1),
      .card2     (card2),
      .card3     (card3),
      .ncards    (ncards),
      .score     (score),
      .deal_ack  (deal_ack),
      .busy      (busy),
      .hand_full (hand_full),
      .natural   (natural)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit clr;
      int code;
      bit acc;
      int c1, c2, c3, n, sc;
      bit nat, full;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(bit clr, int code, bit acc, int c1, int c2, int c3,
                               int n, int sc, bit nat, bit full);
      vec_t v;
      v.clr = clr; v.code = code; v.acc = acc;
      v.c1 = c1; v.c2 = c2; v.c3 = c3; v.n = n; v.sc = sc; v.nat = nat; v.full = full;
      return v;
   endfunction

   function automatic int pts(int c);
      return (c >= 1 && c <= 9) ? c : 0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_hand(input string tag, input int c1, input int c2, input int c3,
                           input int n, input int sc);
      chk({tag, ".card1"}, int'(card1), c1);
      chk({tag, ".card2"}, int'(card2), c2);
      chk({tag, ".card3"}, int'(card3), c3);
      chk({tag, ".ncards"}, int'(ncards), n);
      chk({tag, ".score"}, int'(score), sc);
   endtask

   task automatic wait_shoe(input int code);
      for (int i = 0; i < 30 && int'(next_card) != code; i++) step();
      chk("wait_shoe", int'(next_card), code);
   endtask

   task automatic apply(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      if (v.clr) begin
         clear_hand = 1'b1;
         step();
         clear_hand = 1'b0;
         chk_hand(tag, 0, 0, 0, 0, 0);
         chk({tag, ".natural"}, int'(natural), 0);
      end else begin
         wait_shoe(v.code);
         deal_req = 1'b1;
         step();
         deal_req = 1'b0;
         if (v.acc) begin
            chk({tag, ".c1_n1"}, int'(card1), v.c1);
            chk({tag, ".c2_n1"}, int'(card2), v.c2);
            chk({tag, ".c3_n1"}, int'(card3), v.c3);
            chk({tag, ".ncards_n1"}, int'(ncards), v.n);
            chk({tag, ".busy_n1"}, int'(busy), 1);
            chk({tag, ".ack_n1"}, int'(deal_ack), 0);
            step();
            chk({tag, ".score_n2"}, int'(score), v.sc);
            chk({tag, ".ack_n2"}, int'(deal_ack), 1);
            chk({tag, ".natural_n2"}, int'(natural), int'(v.nat));
            step();
            chk({tag, ".ack_n3"}, int'(deal_ack), 0);
            chk({tag, ".busy_n3"}, int'(busy), 0);
            chk({tag, ".full"}, int'(hand_full), int'(v.full));
         end else begin
            for (int k = 0; k < 3; k++) begin
               chk({tag, ".ack_ignored"}, int'(deal_ack), 0);
               chk({tag, ".busy_ignored"}, int'(busy), 0);
               if (k < 2) step();
            end
            chk_hand(tag, v.c1, v.c2, v.c3, v.n, v.sc);
            chk({tag, ".natural"}, int'(natural), int'(v.nat));
            chk({tag, ".full"}, int'(hand_full), int'(v.full));
         end
      end
   endtask

   // Reference model state for the random phase
   int m_cards[3];
   int m_n, m_scored, m_busy, m_t;
   bit m_ack, m_nat;

   function automatic int m_score();
      int s = 0;
      for (int i = 0; i < m_scored; i++) s += pts(m_cards[i]);
      return s % 10;
   endfunction

   initial begin
      int acks;
      tbl[0]  = mk(0, 7, 1, 7, 0, 0, 1, 7, 0, 0);
      tbl[1]  = mk(0, 6, 1, 7, 6, 0, 2, 3, 0, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 12, 1, 12, 0, 0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 9, 1, 12, 9, 0, 2, 9, NAT, 0);
      tbl[5]  = mk(0, 11, !NAT, 12, 9, NAT ? 0 : 11, NAT ? 2 : 3, 9, NAT, !NAT);
      tbl[6]  = mk(0, 5, 0, 12, 9, NAT ? 0 : 11, NAT ? 2 : 3, 9, NAT, !NAT);
      tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(0, 4, 1, 4, 0, 0, 1, 4, 0, 0);
      tbl[9]  = mk(0, 5, 1, 4, 5, 0, 2, 9, NAT, 0);
      tbl[10] = mk(0, 3, !NAT, 4, 5, NAT ? 0 : 3, NAT ? 2 : 3, NAT ? 9 : 2, NAT, !NAT);
      tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state and shoe sequence
      #12;
      chk("rst.next_card", int'(next_card), 1);
      chk_hand("rst", 0, 0, 0, 0, 0);
      chk("rst.ack", int'(deal_ack), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.natural", int'(natural), 0);
      chk("rst.full", int'(hand_full), 0);
      resetb = 1'b1;
      chk("shoe.first", int'(next_card), 1);
      for (int i = 2; i <= 14; i++) begin
         step();
         chk("shoe.seq", int'(next_card), ((i - 1) % 13) + 1);
      end
      chk_hand("idle", 0, 0, 0, 0, 0);

      for (int i = 0; i < 12; i++) apply(i, tbl[i]);

      // deal_req held for three cycles: one card, one ack
      acks = 0;
      deal_req = 1'b1;
      for (int k = 0; k < 3; k++) begin step(); acks += int'(deal_ack); end
      deal_req = 1'b0;
      for (int k = 0; k < 2; k++) begin step(); acks += int'(deal_ack); end
      chk("held.acks", acks, 1);
      chk("held.ncards", int'(ncards), 1);
      chk("held.busy", int'(busy), 0);

      // clear during LOAD aborts the deal
      clear_hand = 1'b1; step(); clear_hand = 1'b0;
      deal_req = 1'b1; step(); deal_req = 1'b0;
      chk("abort.busy_load", int'(busy), 1);
      clear_hand = 1'b1; step(); clear_hand = 1'b0;
      chk_hand("abort", 0, 0, 0, 0, 0);
      acks = int'(deal_ack);
      for (int k = 0; k < 3; k++) begin step(); acks += int'(deal_ack); end
      chk("abort.acks", acks, 0);
      chk("abort.busy", int'(busy), 0);

      // simultaneous clear and deal: clear wins
      deal_req = 1'b1; clear_hand = 1'b1; step(); deal_req = 1'b0; clear_hand = 1'b0;
      acks = int'(deal_ack);
      for (int k = 0; k < 3; k++) begin step(); acks += int'(deal_ack); end
      chk("both.acks", acks, 0);
      chk_hand("both", 0, 0, 0, 0, 0);

      // reset asserted mid-deal
      deal_req = 1'b1; step(); deal_req = 1'b0;
      chk("midrst.ncards_before", int'(ncards), 1);
      #2 resetb = 1'b0;
      #1;
      chk("midrst.next_card", int'(next_card), 1);
      chk_hand("midrst", 0, 0, 0, 0, 0);
      chk("midrst.busy", int'(busy), 0);
      chk("midrst.ack", int'(deal_ack), 0);
      resetb = 1'b1;

      // Random phase against the reference model
      m_n = 0; m_scored = 0; m_busy = 0; m_t = 0; m_ack = 0; m_nat = 0;
      for (int i = 0; i < 3; i++) m_cards[i] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit d, c;
         int shoe_now;
         d = ($urandom_range(0, 99) < 35);
         c = ($urandom_range(0, 99) < 6);
         deal_req = d;
         clear_hand = c;
         shoe_now = (m_t % 13) + 1;
         step();
         m_t++;
         m_ack = 0;
         if (c) begin
            for (int i = 0; i < 3; i++) m_cards[i] = 0;
            m_n = 0; m_scored = 0; m_busy = 0; m_nat = 0;
         end else if (m_busy == 2) begin
            m_busy = 1;
            m_scored = m_n;
            m_ack = 1;
            if (NAT && m_n == 2 && m_score() >= 8) m_nat = 1;
         end else if (m_busy == 1) begin
            m_busy = 0;
         end else if (d && m_n < 3 && !m_nat) begin
            m_cards[m_n] = shoe_now;
            m_n++;
            m_busy = 2;
         end
         chk("rnd.next_card", int'(next_card), (m_t % 13) + 1);
         chk_hand("rnd", m_cards[0], m_cards[1], m_cards[2], m_n, m_score());
         chk("rnd.ack", int'(deal_ack), int'(m_ack));
         chk("rnd.busy", int'(busy), int'(m_busy != 0));
         chk("rnd.full", int'(hand_full), int'(m_n == 3));
         chk("rnd.natural", int'(natural), int'(m_nat));
      end
      deal_req = 1'b0;
      clear_hand = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
